mlp_layer_sequencer: RTL

Pipelined start/completion scheduler for a chain of `fc_layer` instances in an MLP top (e.g. the 5-layer d8/c256 build). It tracks which layer input buffers hold a valid frame and pulses each layer's `i_start` once its input is full and its downstream buffer is free. It drives each layer's `i_next_busy` back-pressure and reports frame completion and error status to the host. Sits beside the `*_top` wrapper; one instance per network.

---
 rtl/mlp_layer_sequencer_if.sv | 29 ++
 rtl/mlp_layer_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mlp_layer_sequencer_if.sv
// Handshake bundle between the MLP layer sequencer and its host / fc_layer chain.
// The sequencer uses the slave modport; the host side uses master.
interface mlp_layer_sequencer_if #(
  parameter int unsigned num_layers = 5,
  parameter int unsigned cnt_width  = 16
);
  logic                  i_enable;
  logic                  i_frame_valid;
  logic                  o_frame_ready;
  logic [num_layers-1:0] i_busy;
  logic [num_layers-1:0] o_start;
  logic [num_layers-1:0] o_next_busy;
  logic                  o_frame_done;
  logic [cnt_width-1:0]  o_frame_cnt;
  logic                  o_overflow;
  logic [num_layers-1:0] o_timeout;

  modport master (
    output i_enable, i_frame_valid, i_busy,
    input  o_frame_ready, o_start, o_next_busy, o_frame_done, o_frame_cnt,
           o_overflow, o_timeout
  );

  modport slave (
    input  i_enable, i_frame_valid, i_busy,
    output o_frame_ready, o_start, o_next_busy, o_frame_done, o_frame_cnt,
           o_overflow, o_timeout
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Start/completion scheduler for a chain of fc layers: tracks per-layer input
// buffer occupancy, issues start pulses, watches for stuck layers, counts frames.
module mlp_layer_sequencer #(
  parameter int unsigned num_layers    = 5,
  parameter int unsigned start_timeout = 15,
  parameter int unsigned cnt_width     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mlp_layer_sequencer_if.slave bus
);

  localparam int unsigned WD_W = $clog2(start_timeout + 1);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} layer_state_e;

  layer_state_e          state_q [num_layers];
  layer_state_e          state_d [num_layers];
  logic [WD_W-1:0]       wdog_q  [num_layers];
  logic [WD_W-1:0]       wdog_d  [num_layers];

  logic [num_layers-1:0] full_q;
  logic [num_layers-1:0] full_d;
  logic [num_layers:0]   full_ext;
  logic [num_layers-1:0] arm;
  logic [num_layers-1:0] done;
  logic [num_layers-1:0] tmo;
  logic [num_layers-1:0] clr;
  logic [num_layers-1:0] fill;

  logic [num_layers-1:0] start_q;
  logic [num_layers-1:0] timeout_q;
  logic                  ready_q;
  logic                  frame_done_q;
  logic                  overflow_q;
  logic                  overflow_d;
  logic [cnt_width-1:0]  cnt_q;

  // Buffer past the last layer never exists, so the last layer is never blocked.
  assign full_ext = {1'b0, full_q};

  // Set wins over clear: a handoff into a buffer emptied in the same cycle keeps it full.
  assign clr        = done | tmo;
  assign fill       = {done[num_layers-2:0], bus.i_frame_valid};
  assign full_d     = fill | (full_q & ~clr);
  assign overflow_d = overflow_q | (bus.i_frame_valid & full_q[0] & ~clr[0]);

  // Per-layer next state, start request, completion and watchdog expiry.
  always_comb begin
    for (int k = 0; k < int'(num_layers); k++) begin
      state_d[k] = state_q[k];
      wdog_d[k]  = wdog_q[k];
      arm[k]     = 1'b0;
      done[k]    = 1'b0;
      tmo[k]     = 1'b0;
      unique case (state_q[k])
        IDLE: begin
          if (bus.i_enable && full_ext[k] && !full_ext[k+1]) begin
            state_d[k] = ARMED;
            wdog_d[k]  = '0;
            arm[k]     = 1'b1;
          end
        end
        ARMED: begin
          if (bus.i_busy[k]) begin
            state_d[k] = RUN;
          end else if (wdog_q[k] == WD_W'(start_timeout - 1)) begin
            state_d[k] = IDLE;
            tmo[k]     = 1'b1;
          end else begin
            wdog_d[k] = wdog_q[k] + 1'b1;
          end
        end
        RUN: begin
          if (!bus.i_busy[k]) begin
            state_d[k] = IDLE;
            done[k]    = 1'b1;
          end
        end
        default: state_d[k] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(num_layers); k++) begin
        state_q[k] <= IDLE;
        wdog_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < int'(num_layers); k++) begin
        state_q[k] <= state_d[k];
        wdog_q[k]  <= wdog_d[k];
      end
    end
  end

  // Occupancy flags and registered host-visible status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q       <= '0;
      start_q      <= '0;
      timeout_q    <= '0;
      ready_q      <= 1'b1;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      full_q       <= full_d;
      start_q      <= arm;
      timeout_q    <= timeout_q | tmo;
      ready_q      <= ~full_d[0];
      frame_done_q <= done[num_layers-1];
      overflow_q   <= overflow_d;
      cnt_q        <= cnt_q + cnt_width'(done[num_layers-1]);
    end
  end

  assign bus.o_start       = start_q;
  assign bus.o_frame_ready = ready_q;
  assign bus.o_next_busy   = full_ext[num_layers:1];
  assign bus.o_frame_done  = frame_done_q;
  assign bus.o_frame_cnt   = cnt_q;
  assign bus.o_overflow    = overflow_q;
  assign bus.o_timeout     = timeout_q;

endmodule
